pacman_soc_pio_ext: RTL and testbench

Parametrised Avalon-MM parallel I/O port with per-bit direction control, atomic set/clear of outputs, edge capture and a maskable interrupt. It is the general-purpose GPIO peripheral on the pacman_soc interconnect, used wherever a plain input/output PIO lacks bidirectional pins, edge events or an IRQ (OTG HPI handshake lines, buttons, sprite-engine status). Register reads have one cycle of latency.

---
 rtl/pacman_soc_pio_pkg.sv | 24 ++
 rtl/pacman_soc_pio_sync.sv | 46 ++++
 rtl/pacman_soc_pio_ext.sv | 131 +++++++++++++
 tb/tb_pacman_soc_pio_ext.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_soc_pio_pkg.sv
// -----------------------------------------------------------------------------
// pacman_soc_pio_pkg
// Shared constants for the pacman_soc parallel I/O peripheral:
//   - register word addresses on the 3-bit Avalon-MM address bus
//   - encodings of the EDGE_TYPE parameter
// Optional feature macro used by this block: PACMAN_SOC_PIO_SYNC_EN
// (see pacman_soc_pio_sync).
// -----------------------------------------------------------------------------
package pacman_soc_pio_pkg;

  // Register map (word addresses). Addresses 4..7 read as zero.
  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  // EDGE_TYPE encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage : pacman_soc_pio_pkg

// File: rtl/pacman_soc_pio_sync.sv
// -----------------------------------------------------------------------------
// pacman_soc_pio_sync
// Input conditioning stage for the PIO pins.
//   PACMAN_SOC_PIO_SYNC_EN defined   : two-flop synchroniser, q is the 2nd flop
//   PACMAN_SOC_PIO_SYNC_EN undefined : single register stage (on-chip sources)
// All flops reset asynchronously to 0.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   d        in  raw pin inputs (DATA_WIDTH)
//   q        out conditioned inputs (DATA_WIDTH)
// -----------------------------------------------------------------------------
module pacman_soc_pio_sync
  import pacman_soc_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

`ifdef PACMAN_SOC_PIO_SYNC_EN
  logic [DATA_WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end
`endif

endmodule : pacman_soc_pio_sync

// File: rtl/pacman_soc_pio_ext.sv
// -----------------------------------------------------------------------------
// pacman_soc_pio_ext
// General-purpose parallel I/O port on the pacman_soc Avalon-MM interconnect:
// per-bit direction, atomic OUTSET/OUTCLEAR, edge capture, maskable level irq.
// Optional feature macro: PACMAN_SOC_PIO_SYNC_EN (two-flop input synchroniser).
// Parameters:
//   DATA_WIDTH  port width (1..32)
//   EDGE_TYPE   0 rising, 1 falling, 2 any
//   RESET_VALUE reset value of the output data register
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address[2:0]            register word address
//   chipselect, write_n     slave select, active-low write strobe
//   writedata[31:0]         write data (bits above DATA_WIDTH ignored)
//   readdata[31:0]          registered read data (bits above DATA_WIDTH are 0)
//   in_port                 external pin inputs
//   out_port                output data register
//   out_en                  per-bit output enable (DIRECTION register)
//   irq                     registered level interrupt
// -----------------------------------------------------------------------------
module pacman_soc_pio_ext
  import pacman_soc_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  // Bus protocol: a write is taken on every clock edge where chipselect=1 and
  // write_n=0, with no wait states and no acknowledge. There is no read strobe:
  // readdata is re-registered every cycle from address, so a read costs one
  // cycle of latency and has no side effects.

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] direction;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_in_d;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] ec_clr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           rd_next;
  logic                  wr_en;
  logic                  irq_next;
  logic                  unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wdata            = writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^writedata;

  pacman_soc_pio_sync #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (data_in)
  );

  // Edge detection runs on every bit, including output-mode bits; software
  // is expected to mask those through IRQ_MASK.
  always_comb begin
    edge_det = data_in & ~data_in_d;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~data_in & data_in_d;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_det = data_in ^ data_in_d;
    end
  end

  // Write-1-to-clear mask for EDGE_CAPTURE; a new edge in the same cycle wins
  // because it is OR-ed in after the clear.
  assign ec_clr   = (wr_en && (address == ADDR_EDGE_CAPTURE)) ? wdata : '0;
  assign irq_next = |(edge_capture & irq_mask);

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:         rd_next[DATA_WIDTH-1:0] = (data_out & direction) |
                                                   (data_in & ~direction);
      ADDR_DIRECTION:    rd_next[DATA_WIDTH-1:0] = direction;
      ADDR_IRQ_MASK:     rd_next[DATA_WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAPTURE: rd_next[DATA_WIDTH-1:0] = edge_capture;
      default:           rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= RESET_VALUE;
      direction    <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      data_in_d    <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:      data_out  <= wdata;
          ADDR_DIRECTION: direction <= wdata;
          ADDR_IRQ_MASK:  irq_mask  <= wdata;
          ADDR_OUTSET:    data_out  <= data_out | wdata;
          ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
          default:        ;
        endcase
      end
      edge_capture <= (edge_capture & ~ec_clr) | edge_det;
      data_in_d    <= data_in;
      irq          <= irq_next;
      readdata     <= rd_next;
    end
  end

  assign out_port = data_out;
  assign out_en   = direction;

endmodule : pacman_soc_pio_ext

// File: tb/tb_pacman_soc_pio_ext.sv
// -----------------------------------------------------------------------------
// tb_pacman_soc_pio_ext
// Directed bench for pacman_soc_pio_ext (DATA_WIDTH=16, EDGE_TYPE=rising,
// RESET_VALUE=16'hA5A5). A vector table covers register access and the
// output path; hand-written sequences cover edge/irq timing, set-wins-over-
// clear and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pacman_soc_pio_ext;
  import pacman_soc_pio_pkg::*;

`ifdef PACMAN_SOC_PIO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] out_en;
  logic        irq;

  always #5 clk = ~clk;

  pacman_soc_pio_ext #(
    .DATA_WIDTH (16),
    .EDGE_TYPE  (0),
    .RESET_VALUE(16'hA5A5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .out_en    (out_en),
    .irq       (irq)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- drivers
  // All driving and sampling happens on the falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic check_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    exp_q.push_back(exp);
    bus_read(a, rd);
    check(name, rd, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef enum logic [1:0] {OP_IDLE, OP_WR, OP_RD} op_e;

  typedef struct {
    string       name;
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [15:0] pins;
    logic [15:0] exp_out;
    logic [15:0] exp_oen;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;

    vecs.push_back('{"wr_data",      OP_WR,   ADDR_DATA,         32'h0000_1234, 16'h0000, 16'h1234, 16'h0000, 32'h0});
    vecs.push_back('{"wr_dir",       OP_WR,   ADDR_DIRECTION,    32'h0000_00FF, 16'h0000, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"pins_abcd",    OP_IDLE, 3'd0,              32'd4,         16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_data_mix",  OP_RD,   ADDR_DATA,         32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0000_AB34});
    vecs.push_back('{"rd_dir",       OP_RD,   ADDR_DIRECTION,    32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0000_00FF});
    vecs.push_back('{"rd_addr4",     OP_RD,   3'd4,              32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_addr5",     OP_RD,   3'd5,              32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_addr7",     OP_RD,   3'd7,              32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"wr_data_f0",   OP_WR,   ADDR_DATA,         32'h0000_00F0, 16'hABCD, 16'h00F0, 16'h00FF, 32'h0});
    vecs.push_back('{"outset",       OP_WR,   ADDR_OUTSET,       32'h0000_000F, 16'hABCD, 16'h00FF, 16'h00FF, 32'h0});
    vecs.push_back('{"outclear",     OP_WR,   ADDR_OUTCLEAR,     32'h0000_0030, 16'hABCD, 16'h00CF, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_data_cf",   OP_RD,   ADDR_DATA,         32'h0,         16'hABCD, 16'h00CF, 16'h00FF, 32'h0000_ABCF});
    vecs.push_back('{"wr_data_hi",   OP_WR,   ADDR_DATA,         32'hFFFF_1234, 16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_ec_rise",   OP_RD,   ADDR_EDGE_CAPTURE, 32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0000_ABCD});
    vecs.push_back('{"w1c_partial",  OP_WR,   ADDR_EDGE_CAPTURE, 32'h0000_00CD, 16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_ec_part",   OP_RD,   ADDR_EDGE_CAPTURE, 32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0000_AB00});
    vecs.push_back('{"w1c_all",      OP_WR,   ADDR_EDGE_CAPTURE, 32'h0000_FFFF, 16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_ec_zero",   OP_RD,   ADDR_EDGE_CAPTURE, 32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"wr_mask",      OP_WR,   ADDR_IRQ_MASK,     32'h0000_0003, 16'hABCD, 16'h1234, 16'h00FF, 32'h0});
    vecs.push_back('{"rd_mask",      OP_RD,   ADDR_IRQ_MASK,     32'h0,         16'hABCD, 16'h1234, 16'h00FF, 32'h0000_0003});
    vecs.push_back('{"wr_dir_in",    OP_WR,   ADDR_DIRECTION,    32'h0,         16'hABCD, 16'h1234, 16'h0000, 32'h0});
    vecs.push_back('{"pins_zero",    OP_IDLE, 3'd0,              32'd4,         16'h0000, 16'h1234, 16'h0000, 32'h0});
    vecs.push_back('{"rd_ec_nofall", OP_RD,   ADDR_EDGE_CAPTURE, 32'h0,         16'h0000, 16'h1234, 16'h0000, 32'h0});

    // -------------------------------------------------------------- reset
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    idle(3);
    check("rst_out_port", {16'h0, out_port}, 32'h0000_A5A5);
    check("rst_out_en",   {16'h0, out_en},   32'h0);
    check("rst_irq",      {31'h0, irq},      32'h0);
    check("rst_readdata", readdata,          32'h0);
    reset_n = 1'b1;
    idle(2);

    // -------------------------------------------------------------- table
    foreach (vecs[i]) begin
      in_port = vecs[i].pins;
      case (vecs[i].op)
        OP_WR: bus_write(vecs[i].addr, vecs[i].data);
        OP_RD: check_read({vecs[i].name, "_rd"}, vecs[i].addr, vecs[i].exp_rd);
        default: idle(int'(vecs[i].data));
      endcase
      check({vecs[i].name, "_out"}, {16'h0, out_port}, {16'h0, vecs[i].exp_out});
      check({vecs[i].name, "_oen"}, {16'h0, out_en},   {16'h0, vecs[i].exp_oen});
    end

    // -------------------------------------------------------------- rising edge -> capture -> irq
    check("pre_irq_low", {31'h0, irq}, 32'h0);
    in_port = 16'h0001;
    idle(LAT + 1);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, irq}, 32'h1);
    check_read("ec_bit0", ADDR_EDGE_CAPTURE, 32'h1);

    // clear alone: irq drops one edge after the clearing edge
    bus_write(ADDR_EDGE_CAPTURE, 32'h1);
    check("irq_hold_clr", {31'h0, irq}, 32'h1);
    idle(1);
    check("irq_drop_clr", {31'h0, irq}, 32'h0);

    // falling edge captures nothing with EDGE_TYPE rising
    in_port = 16'h0000;
    idle(LAT + 3);
    check_read("ec_fall_none", ADDR_EDGE_CAPTURE, 32'h0);
    check("irq_fall_none", {31'h0, irq}, 32'h0);

    // -------------------------------------------------------------- set wins over clear
    in_port = 16'h0001;
    idle(LAT + 3);
    check("irq_set_again", {31'h0, irq}, 32'h1);
    in_port = 16'h0000;
    idle(LAT + 3);
    in_port = 16'h0001;
    idle(LAT);
    bus_write(ADDR_EDGE_CAPTURE, 32'h1);
    check("irq_set_wins0", {31'h0, irq}, 32'h1);
    idle(1);
    check("irq_set_wins1", {31'h0, irq}, 32'h1);
    check_read("ec_set_wins", ADDR_EDGE_CAPTURE, 32'h1);
    bus_write(ADDR_EDGE_CAPTURE, 32'h1);
    check("irq_late_hold", {31'h0, irq}, 32'h1);
    idle(1);
    check("irq_late_drop", {31'h0, irq}, 32'h0);
    check_read("ec_late_zero", ADDR_EDGE_CAPTURE, 32'h0);

    // -------------------------------------------------------------- async reset mid-write
    in_port = 16'h0000;
    idle(LAT + 2);
    in_port = 16'h0003;
    idle(LAT + 3);
    check_read("ec_pre_rst", ADDR_EDGE_CAPTURE, 32'h3);
    check("irq_pre_rst", {31'h0, irq}, 32'h1);
    address    = ADDR_DATA;
    writedata  = 32'h0000_5555;
    chipselect = 1'b1;
    write_n    = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_irq",      {31'h0, irq},      32'h0);
    check("arst_out_port", {16'h0, out_port}, 32'h0000_A5A5);
    check("arst_out_en",   {16'h0, out_en},   32'h0);
    check("arst_readdata", readdata,          32'h0);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    // in_port held high across reset: first cycle out of reset sees one edge
    idle(LAT + 3);
    check("post_rst_out", {16'h0, out_port}, 32'h0000_A5A5);
    check_read("post_rst_ec",   ADDR_EDGE_CAPTURE, 32'h3);
    check_read("post_rst_mask", ADDR_IRQ_MASK,     32'h0);
    check_read("post_rst_dir",  ADDR_DIRECTION,    32'h0);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    // -------------------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_pacman_soc_pio_ext
